// File: rtl/spell_mem_banked.sv
// spell_mem_banked
//   Banked on-chip memory for the SPELL core: region 0 holds code, regions
//   1..2**REGION_BITS-1 hold data. After reset an init sweep writes every word
//   with its region's init value; clear_req re-runs that sweep for one region.
//   Accesses use the select/data_ready handshake with WAIT_STATES extra
//   cycles ahead of each access.
//
//   Optional build macro: SPELL_MEM_PARITY_EN
//     When defined, every stored word carries an even-parity bit and reads
//     report parity_error. When undefined, parity_error is always 0.
//
// Ports
//   clk          in   clock, all state on rising edge
//   rst          in   synchronous active-high reset
//   select       in   access request, held until data_ready, then dropped
//   write        in   1 = write, 0 = read
//   region       in   target region (0 = code)
//   addr         in   word address within the region
//   data_in      in   write data
//   clear_req    in   one-cycle pulse: reinitialise clear_region
//   clear_region in   region to clear, sampled with clear_req
//   data_out     out  registered read data
//   data_ready   out  access complete, held while select stays high
//   mem_ready    out  no init/clear sweep running
//   parity_error out  registered with data_out on reads
module spell_mem_banked #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned REGION_BITS = 1,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] CODE_INIT_VALUE = '1,
  parameter logic [DATA_WIDTH-1:0] DATA_INIT_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   select,
  input  logic                   write,
  input  logic [REGION_BITS-1:0] region,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   clear_req,
  input  logic [REGION_BITS-1:0] clear_region,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   data_ready,
  output logic                   mem_ready,
  output logic                   parity_error
);

  localparam int unsigned IDX_W = REGION_BITS + ADDR_WIDTH;
  localparam int unsigned DEPTH = 2 ** IDX_W;
`ifdef SPELL_MEM_PARITY_EN
  localparam int unsigned MEM_W = DATA_WIDTH + 1;
`else
  localparam int unsigned MEM_W = DATA_WIDTH;
`endif
  localparam logic [2:0]            WS_LOAD   = 3'(WAIT_STATES);
  localparam logic [IDX_W-1:0]      IDX_LAST  = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_CLEAR
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [2:0]              wcnt_q, wcnt_d;
  logic [REGION_BITS-1:0]  clr_reg_q, clr_reg_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    ready_q, ready_d;
  logic                    mem_ready_q, mem_ready_d;
  logic                    perr_q, perr_d;

  logic [MEM_W-1:0]        mem_q [DEPTH];

  logic                    mem_we;
  logic [IDX_W-1:0]        mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    do_access;
  logic [IDX_W-1:0]        acc_idx;
  logic [MEM_W-1:0]        rd_word;

  function automatic logic [DATA_WIDTH-1:0] init_val(input logic [REGION_BITS-1:0] r);
    return (r == '0) ? CODE_INIT_VALUE : DATA_INIT_VALUE;
  endfunction

  function automatic logic [MEM_W-1:0] encode(input logic [DATA_WIDTH-1:0] d);
`ifdef SPELL_MEM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  assign acc_idx = {region, addr};
  assign rd_word = mem_q[acc_idx];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    wcnt_d      = wcnt_q;
    clr_reg_d   = clr_reg_q;
    data_out_d  = data_out_q;
    ready_d     = ready_q;
    mem_ready_d = mem_ready_q;
    perr_d      = perr_q;
    mem_we      = 1'b0;
    mem_waddr   = ptr_q;
    mem_wdata   = '0;
    do_access   = 1'b0;

    unique case (state_q)
      S_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = init_val(ptr_q[IDX_W-1 -: REGION_BITS]);
        if (ptr_q == IDX_LAST) begin
          ptr_d       = '0;
          state_d     = S_IDLE;
          mem_ready_d = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      S_IDLE: begin
        // A clear arriving with a new request takes priority; the request
        // stays asserted and is picked up here once the sweep ends.
        if (clear_req) begin
          state_d     = S_CLEAR;
          mem_ready_d = 1'b0;
          clr_reg_d   = clear_region;
          ptr_d       = '0;
        end else if (select) begin
          if (wcnt_q == 3'd0) begin
            do_access = 1'b1;
          end else begin
            // First wait cycle is counted on entry so the access lands on
            // edge WAIT_STATES+1.
            wcnt_d  = wcnt_q - 3'd1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wcnt_q == 3'd0) begin
          do_access = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 3'd1;
        end
      end
      S_DONE: begin
        if (!select) begin
          ready_d = 1'b0;
          perr_d  = 1'b0;
          wcnt_d  = WS_LOAD;
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = {clr_reg_q, ptr_q[ADDR_WIDTH-1:0]};
        mem_wdata = init_val(clr_reg_q);
        if (ptr_q[ADDR_WIDTH-1:0] == ADDR_LAST) begin
          ptr_d       = '0;
          state_d     = S_IDLE;
          mem_ready_d = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = S_INIT;
    endcase

    if (do_access) begin
      state_d = S_DONE;
      ready_d = 1'b1;
      if (write) begin
        mem_we    = 1'b1;
        mem_waddr = acc_idx;
        mem_wdata = data_in;
        perr_d    = 1'b0;
      end else begin
        data_out_d = rd_word[DATA_WIDTH-1:0];
`ifdef SPELL_MEM_PARITY_EN
        perr_d = ^rd_word;
`else
        perr_d = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      ptr_q       <= '0;
      wcnt_q      <= WS_LOAD;
      clr_reg_q   <= '0;
      data_out_q  <= '0;
      ready_q     <= 1'b0;
      mem_ready_q <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wcnt_q      <= wcnt_d;
      clr_reg_q   <= clr_reg_d;
      data_out_q  <= data_out_d;
      ready_q     <= ready_d;
      mem_ready_q <= mem_ready_d;
      perr_q      <= perr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[mem_waddr] <= encode(mem_wdata);
    end
  end

  assign data_out     = data_out_q;
  assign data_ready   = ready_q;
  assign mem_ready    = mem_ready_q;
  assign parity_error = perr_q;

endmodule

// File: tb/tb_spell_mem_banked.sv
module tb_spell_mem_banked;

  typedef struct {
    logic       is_read;
    logic [7:0] data;
    logic       par;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default configuration; DUT B: three wait states
  logic       rst_a = 1'b1, sel_a = 1'b0, wr_a = 1'b0, clr_a = 1'b0;
  logic [0:0] reg_a = '0, clrreg_a = '0;
  logic [7:0] addr_a = '0, din_a = '0;
  logic [7:0] dout_a;
  logic       rdy_a, mrdy_a, perr_a;

  logic       rst_b = 1'b1, sel_b = 1'b0, wr_b = 1'b0, clr_b = 1'b0;
  logic [0:0] reg_b = '0, clrreg_b = '0;
  logic [7:0] addr_b = '0, din_b = '0;
  logic [7:0] dout_b;
  logic       rdy_b, mrdy_b, perr_b;

  spell_mem_banked dut (
    .clk(clk), .rst(rst_a), .select(sel_a), .write(wr_a), .region(reg_a),
    .addr(addr_a), .data_in(din_a), .clear_req(clr_a), .clear_region(clrreg_a),
    .data_out(dout_a), .data_ready(rdy_a), .mem_ready(mrdy_a),
    .parity_error(perr_a)
  );

  spell_mem_banked #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst_b), .select(sel_b), .write(wr_b), .region(reg_b),
    .addr(addr_b), .data_in(din_b), .clear_req(clr_b), .clear_region(clrreg_b),
    .data_out(dout_b), .data_ready(rdy_b), .mem_ready(mrdy_b),
    .parity_error(perr_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic prev_a = 1'b0, prev_b = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every rising data_ready consumes one expected access.
  always @(negedge clk) begin
    exp_t e;
    if (rdy_a && !prev_a) begin
      if (qa.size() == 0) check("a_unexpected_ready", 32'd1, 32'd0);
      else begin
        e = qa.pop_front();
        if (e.is_read) begin
          check("a_read_data", {24'd0, dout_a}, {24'd0, e.data});
          check("a_read_parity", {31'd0, perr_a}, {31'd0, e.par});
        end
      end
    end
    if (rdy_b && !prev_b) begin
      if (qb.size() == 0) check("b_unexpected_ready", 32'd1, 32'd0);
      else begin
        e = qb.pop_front();
        if (e.is_read) check("b_read_data", {24'd0, dout_b}, {24'd0, e.data});
      end
    end
    prev_a = rdy_a;
    prev_b = rdy_b;
  end

  function automatic logic ready_of(input bit b);
    return b ? rdy_b : rdy_a;
  endfunction

  // Caller is positioned 1 time unit after a rising edge.
  task automatic do_access(input bit b, input bit wr, input logic rg, input logic [7:0] ad,
                           input logic [7:0] dat, input bit epar, input int exp_lat,
                           input int hold, input string nm);
    exp_t e;
    int edges;
    e.is_read = !wr; e.data = dat; e.par = epar;
    if (b) begin
      qb.push_back(e);
      wr_b = wr; reg_b = rg; addr_b = ad; din_b = dat; sel_b = 1'b1;
    end else begin
      qa.push_back(e);
      wr_a = wr; reg_a = rg; addr_a = ad; din_a = dat; sel_a = 1'b1;
    end
    edges = 0;
    while (1) begin
      @(posedge clk); #1;
      edges++;
      if (ready_of(b)) break;
      if (edges >= 2000) begin
        check({nm, "_timeout"}, 32'd1, 32'd0);
        break;
      end
    end
    if (exp_lat > 0) check({nm, "_latency"}, edges, exp_lat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({nm, "_hold_ready"}, {31'd0, ready_of(b)}, 32'd1);
      if (!wr) check({nm, "_hold_data"}, {24'd0, b ? dout_b : dout_a}, {24'd0, dat});
    end
    if (b) sel_b = 1'b0; else sel_a = 1'b0;
    @(posedge clk); #1;
    check({nm, "_ready_fall"}, {31'd0, ready_of(b)}, 32'd0);
  endtask

  task automatic wait_init_a(input string nm);
    int n;
    n = 0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      if (mrdy_a || n >= 5000) break;
    end
    check(nm, n, 512);
  endtask

  task automatic check_outputs_zero_a(input string nm);
    check({nm, "_dout"}, {24'd0, dout_a}, 32'd0);
    check({nm, "_ready"}, {31'd0, rdy_a}, 32'd0);
    check({nm, "_mem_ready"}, {31'd0, mrdy_a}, 32'd0);
    check({nm, "_perr"}, {31'd0, perr_a}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero_a("reset");
    rst_a = 1'b0;
    rst_b = 1'b0;
    wait_init_a("init_edges");

    // Init contents at both ends of each region
    do_access(0, 0, 1'b0, 8'h00, 8'hFF, 0, 1, 0, "rd_code_00");
    do_access(0, 0, 1'b0, 8'hFF, 8'hFF, 0, 1, 0, "rd_code_ff");
    do_access(0, 0, 1'b1, 8'h00, 8'h00, 0, 1, 0, "rd_data_00");
    do_access(0, 0, 1'b1, 8'hFF, 8'h00, 0, 1, 0, "rd_data_ff");

    // Write / read-back, other region untouched
    do_access(0, 1, 1'b1, 8'h3C, 8'hA5, 0, 1, 0, "wr_data_3c");
    do_access(0, 0, 1'b1, 8'h3C, 8'hA5, 0, 1, 2, "rd_data_3c");
    do_access(0, 0, 1'b0, 8'h3C, 8'hFF, 0, 1, 0, "rd_code_3c");
    do_access(0, 1, 1'b0, 8'h05, 8'h12, 0, 1, 0, "wr_code_05");
    do_access(0, 0, 1'b0, 8'h05, 8'h12, 0, 1, 0, "rd_code_05_new");

    // Clear of region 0 collides with a data read request
    qa.push_back('{is_read: 1'b1, data: 8'hA5, par: 1'b0});
    clr_a = 1'b1; clrreg_a = 1'b0;
    wr_a = 1'b0; reg_a = 1'b1; addr_a = 8'h3C; sel_a = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0;
    check("clear_entry_mem_ready", {31'd0, mrdy_a}, 32'd0);
    n = 0; seen = 0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      if (rdy_a) seen = 1;
      if (mrdy_a || n >= 2000) break;
    end
    check("clear_edges", n, 256);
    check("clear_no_ready", {31'd0, seen}, 32'd0);
    n = 0;
    while (!rdy_a && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("pending_after_clear_latency", n, 1);
    sel_a = 1'b0;
    @(posedge clk); #1;
    check("pending_ready_fall", {31'd0, rdy_a}, 32'd0);
    do_access(0, 0, 1'b0, 8'h05, 8'hFF, 0, 1, 0, "rd_code_05_cleared");
    do_access(0, 0, 1'b1, 8'h3C, 8'hA5, 0, 1, 0, "rd_data_3c_kept");

    // Reset during init
    rst_a = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero_a("rst_idle");
    rst_a = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("mid_init_mem_ready", {31'd0, mrdy_a}, 32'd0);
    rst_a = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero_a("rst_mid_init");
    rst_a = 1'b0;
    wait_init_a("reinit_edges");
    do_access(0, 0, 1'b0, 8'h05, 8'hFF, 0, 1, 0, "rd_code_05_reinit");
    do_access(0, 0, 1'b1, 8'h3C, 8'h00, 0, 1, 0, "rd_data_3c_reinit");

    // Reset during a clear of region 1
    do_access(0, 1, 1'b1, 8'h20, 8'h77, 0, 1, 0, "wr_data_20");
    do_access(0, 0, 1'b1, 8'h20, 8'h77, 0, 1, 0, "rd_data_20");
    clr_a = 1'b1; clrreg_a = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0;
    check("clear1_entry_mem_ready", {31'd0, mrdy_a}, 32'd0);
    repeat (50) @(posedge clk);
    #1;
    rst_a = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero_a("rst_mid_clear");
    rst_a = 1'b0;
    wait_init_a("reinit2_edges");
    do_access(0, 0, 1'b1, 8'h20, 8'h00, 0, 1, 0, "rd_data_20_reinit");
    do_access(0, 0, 1'b0, 8'hFF, 8'hFF, 0, 1, 0, "rd_code_ff_reinit");

    // Three wait states on the second instance
    check("b_mem_ready", {31'd0, mrdy_b}, 32'd1);
    do_access(1, 1, 1'b1, 8'h10, 8'h5A, 0, 4, 0, "b_wr_data_10");
    do_access(1, 0, 1'b1, 8'h10, 8'h5A, 0, 4, 10, "b_rd_data_10");
    do_access(1, 0, 1'b0, 8'h10, 8'hFF, 0, 4, 0, "b_rd_code_10");

`ifdef SPELL_MEM_PARITY_EN
    dut.mem_q[9'h110] = dut.mem_q[9'h110] ^ 9'h001;
    do_access(0, 0, 1'b1, 8'h10, 8'h01, 1, 1, 1, "rd_parity_flip");
    check("parity_cleared", {31'd0, perr_a}, 32'd0);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("queue_a_drained", qa.size(), 0);
    check("queue_b_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spell_mem_banked.md
# spell_mem_banked

Parametrised on-chip memory for the SPELL core. It holds a code region plus one or more data regions, with configurable word width, region depth and wait states. After reset it runs an automatic init sweep, and it supports an on-demand per-region clear. It sits between the SPELL execution unit and its storage, and uses the same select/data_ready access handshake as the existing internal memory.

## Interface
Parameters:
- ADDR_WIDTH, 8: word address width within one region; region depth 2**ADDR_WIDTH.
- DATA_WIDTH, 8: word width.
- REGION_BITS, 1: region select width; 2**REGION_BITS regions, region 0 = code.
- WAIT_STATES, 0: extra cycles before each access is performed (0..7).
- CODE_INIT_VALUE, all ones: init/clear value for region 0.
- DATA_INIT_VALUE, all zeros: init/clear value for all other regions.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- select  in  1  access request; held until data_ready, then dropped.
- write  in  1  1 = write, 0 = read; stable while select.
- region  in  REGION_BITS  target region; stable while select.
- addr  in  ADDR_WIDTH  word address; stable while select.
- data_in  in  DATA_WIDTH  write data; stable while select.
- clear_req  in  1  one-cycle pulse: reinitialise one region.
- clear_region  in  REGION_BITS  region to clear; sampled with clear_req.
- data_out  out  DATA_WIDTH  registered read data.
- data_ready  out  1  access complete.
- mem_ready  out  1  no init/clear sweep running.
- parity_error  out  1  read data failed parity (see Configuration).

## Operation
- Storage is a behavioural array of 2**(REGION_BITS+ADDR_WIDTH) words, indexed {region, addr}.
- Reset values:
  - data_out = 0, data_ready = 0, mem_ready = 0, parity_error = 0.
  - Sweep pointer = 0, wait counter = WAIT_STATES.
- State machine with states INIT, IDLE, WAIT, DONE, CLEAR.
- INIT:
  - Writes one word per cycle from index 0 upward.
  - Writes CODE_INIT_VALUE when the index falls in region 0, DATA_INIT_VALUE otherwise.
  - After the last index it moves to IDLE and sets mem_ready = 1.
- IDLE:
  - select = 1 with counter 0 performs the access this edge and moves to DONE.
  - select = 1 with counter > 0 moves to WAIT.
- WAIT: the counter decrements once per cycle; the access is performed on the edge where the counter reads 0.
- Access:
  - Write stores data_in.
  - Read loads data_out from the array.
  - data_ready is set to 1 on the same edge.
- DONE:
  - data_ready and data_out hold while select = 1.
  - Exactly one access is performed per select assertion.
  - select = 0 clears data_ready, reloads the counter and returns to IDLE.
  - Back-to-back accesses therefore need select low for at least one cycle.
- CLEAR:
  - Entered from IDLE on clear_req.
  - mem_ready = 0.
  - Writes the region's init value to all 2**ADDR_WIDTH words of clear_region, one per cycle, addr 0 upward.
  - Then returns to IDLE with mem_ready = 1.
- clear_req is ignored in INIT, CLEAR, WAIT and DONE.
- clear_req and select rising in the same IDLE cycle: clear wins. The access stays pending and starts from IDLE after the clear.
- select asserted during INIT or CLEAR: data_ready stays 0; the access is served after the sweep.
- rst mid-operation: all state returns to reset values and INIT restarts at index 0. An interrupted access or clear is lost.
- Sweep and wait counters wrap only at their terminal values; no modular overflow is visible.

## Timing
- Init takes N = 2**(REGION_BITS+ADDR_WIDTH) cycles. Word 0 is written on the first edge with rst = 0 and word N-1 on edge N. mem_ready is 1 after edge N (defaults: 512 edges).
- Access latency, from the first edge sampling select = 1 in IDLE: data_ready and data_out are valid after WAIT_STATES+1 edges.
- data_ready falls one edge after select is sampled low.
- A clear costs 2**ADDR_WIDTH cycles; mem_ready is low for exactly that many edges.
- Write-then-read of the same word returns the new value, since the accesses are sequential.

## Configuration
- SPELL_MEM_PARITY_EN defined:
  - Each array word carries one extra even-parity bit, computed on every write (access, init, clear).
  - On read, parity_error is registered together with data_out: 1 if the stored parity mismatches, else 0.
  - parity_error is cleared when data_ready falls and is 0 on writes.
- Undefined: the array is DATA_WIDTH wide and parity_error is tied to 0.

## Test plan
- Reset, defaults -> mem_ready rises after exactly 512 edges; reads give code region 0xFF at addr 0x00/0xFF and data region 0x00 at addr 0x00/0xFF.
- Write 0xA5 to data region addr 0x3C, then read it back, WAIT_STATES = 0 -> data_ready one edge after select each time; read returns 0xA5, code addr 0x3C still 0xFF.
- WAIT_STATES = 3: read -> data_ready after exactly 4 edges; holding select 10 cycles performs one access; data_ready drops one edge after select falls.
- Write 0x12 to code addr 0x05, pulse clear_req with clear_region = 0 in the same cycle as a data-region read request -> mem_ready low 256 edges; code addr 0x05 reads 0xFF; the pending read completes after mem_ready returns.
- Assert rst mid-INIT (edge 100) and mid-CLEAR -> all outputs return to 0; a full 512-cycle init reruns; array contents equal the init values.
- SPELL_MEM_PARITY_EN: normal reads give parity_error = 0; bench flips a stored bit at data addr 0x10 -> the read gives parity_error = 1, cleared after select drops.
